// File: rtl/uart_rx.sv
// 8-bit UART receiver: idle-high line, one low start bit, eight data bits LSB
// first, stop bit high. The line is oversampled on baud_clk. Each bit is sampled
// at mid-cell, and received bytes go to the consumer over a valid/ready handshake.
`timescale 1ns/1ps
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [CW-1:0]          os_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;

  logic os_clr, os_inc, bit_clr, shift, load, ferr_set;

  // rx_in synchroniser. Flops reset to the idle (high) line level.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  assign rxs  = sync[SYNC_STAGES-1];
  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-tick control strobes.
  always_comb begin
    state_next = state;
    os_clr     = 1'b0;
    os_inc     = 1'b0;
    bit_clr    = 1'b0;
    shift      = 1'b0;
    load       = 1'b0;
    ferr_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          os_clr     = 1'b1;
        end
      end
      START: begin
        if (os_cnt == MID) begin
          os_clr  = 1'b1;
          bit_clr = 1'b1;
          // A line that is high again at mid start bit was a glitch.
          state_next = rxs ? IDLE : DATA;
        end else begin
          os_inc = 1'b1;
        end
      end
      DATA: begin
        if (os_cnt == LAST) begin
          os_clr = 1'b1;
          shift  = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end else begin
          os_inc = 1'b1;
        end
      end
      STOP: begin
        if (os_cnt == LAST) begin
          if (rxs) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          os_inc = 1'b1;
        end
      end
      BREAK: begin
        // A low line reports one frame_err. The FSM waits here until the line goes high.
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Oversample tick counter and data-bit counter.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      if (os_clr)      os_cnt <= '0;
      else if (os_inc) os_cnt <= os_cnt + 1'b1;
      if (bit_clr)     bit_cnt <= '0;
      else if (shift)  bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift register. Bits enter at the MSB so the first (LSB) bit ends at bit 0.
  always_ff @(posedge baud_clk) begin
    if (shift) shreg <= {rxs, shreg[7:1]};
  end

  // Output byte, handshake and one-cycle error pulses.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= load && data_valid && !data_ready;
      if (load) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with OVERSAMPLE=16 and SYNC_STAGES=2.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       baud_clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int ov_cnt = 0, fe_cnt = 0, dvh_cnt = 0, busy_cnt = 0;
  int rise_cyc = 0, start_cyc = 0;
  logic prev_dv = 1'b0;
  logic [7:0] acc[$];

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .baud_clk  (baud_clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Count pulses, record the accepted bytes and the rising edges of data_valid.
  always @(negedge baud_clk) begin
    if (overrun)    ov_cnt   <= ov_cnt + 1;
    if (frame_err)  fe_cnt   <= fe_cnt + 1;
    if (data_valid) dvh_cnt  <= dvh_cnt + 1;
    if (busy)       busy_cnt <= busy_cnt + 1;
    if (data_valid && !prev_dv) rise_cyc <= cyc;
    if (data_valid && data_ready) acc.push_back(data_out);
    prev_dv <= data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge baud_clk);
      #1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int t);
    if (t < 16)       return 1'b0;
    else if (t < 144) return b[(t - 16) / 16];
    else              return 1'b1;
  endfunction

  // Drives one frame with a one-cell stop bit. nticks < 160 drives only part of the frame.
  task automatic send(input logic [7:0] b, input int nticks = 160);
    start_cyc = cyc;
    for (int t = 0; t < nticks; t++) begin
      rx_in = frame_bit(b, t);
      tick(1);
    end
  endtask

  int ov0, fe0, b0, d0;

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    data_ready = 1'b0;
    tick(3);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick(4);

    // 0x4B frame with data_ready=0
    fe0 = fe_cnt;
    send(8'h4B);
    chk("f4b_data", 32'(data_out), 32'h4B);
    chk("f4b_valid", 32'(data_valid), 32'd1);
    chk("f4b_latency", 32'(rise_cyc - start_cyc), 32'd155);
    chk("f4b_busy", 32'(busy), 32'd0);
    chk("f4b_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    tick(20);
    chk("f4b_held_valid", 32'(data_valid), 32'd1);
    chk("f4b_held_data", 32'(data_out), 32'h4B);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    chk("f4b_taken", 32'(data_valid), 32'd0);

    // Start-bit glitch
    b0 = busy_cnt;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(32);
    chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(data_valid), 32'd0);

    // Low stop bit followed by a long break
    fe0 = fe_cnt;
    rx_in = 1'b0;
    tick(50 * 16);
    chk("break_one_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("break_no_valid", 32'(data_valid), 32'd0);
    chk("break_busy", 32'(busy), 32'd1);
    rx_in = 1'b1;
    tick(32);
    chk("break_released", 32'(busy), 32'd0);
    send(8'h5A);
    chk("f5a_data", 32'(data_out), 32'h5A);
    chk("f5a_valid", 32'(data_valid), 32'd1);
    chk("f5a_ferr_total", 32'(fe_cnt - fe0), 32'd1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;

    // Overrun: two back-to-back frames, nothing read
    ov0 = ov_cnt;
    send(8'h11);
    send(8'h22);
    chk("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    chk("ovr_taken", 32'(data_valid), 32'd0);

    // data_ready tied high across three back-to-back frames
    data_ready = 1'b1;
    acc.delete();
    d0 = dvh_cnt;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'hA5);
    tick(4);
    chk("rdy_valid_cycles", 32'(dvh_cnt - d0), 32'd3);
    chk("rdy_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("rdy_byte0", 32'(acc[0]), 32'h00);
      chk("rdy_byte1", 32'(acc[1]), 32'hFF);
      chk("rdy_byte2", 32'(acc[2]), 32'hA5);
    end
    chk("rdy_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    chk("rdy_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    data_ready = 1'b0;

    // Asynchronous reset during data bit 4
    send(8'h77);
    chk("pre_rst_valid", 32'(data_valid), 32'd1);
    send(8'hC3, 16 * 5 + 8);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_valid", 32'(data_valid), 32'd0);
    chk("arst_data", 32'(data_out), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    rx_in = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    send(8'h3C);
    chk("f3c_data", 32'(data_out), 32'h3C);
    chk("f3c_valid", 32'(data_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
